// File: rtl/bitstream_decode_if.sv
// Handshake and result bus between the stochastic-stream source, the decoder and the sample consumer.
interface bitstream_decode_if #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
);
  localparam int CW = $clog2(BITSTREAM) + 1;

  logic             in_valid;
  logic             in_ready;
  logic             bit_in;
  logic             out_valid;
  logic             out_ready;
  logic [QUANT-1:0] data;
  logic [CW-1:0]    ones;

  modport master (
    output in_valid, bit_in, out_ready,
    input  in_ready, out_valid, data, ones
  );

  modport slave (
    input  in_valid, bit_in, out_ready,
    output in_ready, out_valid, data, ones
  );
endinterface

// File: rtl/bitstream_decode.sv
// Stochastic-bitstream decoder: counts ones over a BITSTREAM-bit frame and maps the count to a signed sample.
// Optional build macro BITSTREAM_DECODE_SAT_EN clamps the sample to [1-H, H-1] instead of wrapping.
//
// state | meaning
// ACC   | accepting frame bits, in_ready=1
// DONE  | decoded sample presented, waiting for out_ready
module bitstream_decode #(
  parameter int BITSTREAM = 64,
  parameter int QUANT     = 8
) (
  input  logic               clk,
  input  logic               rst,
  bitstream_decode_if.slave  bus
);
  localparam int L = $clog2(BITSTREAM);
  localparam int S = QUANT - L;
  localparam int H = 2 ** (QUANT - 1);
  localparam logic [L-1:0] LAST_IDX = L'(BITSTREAM - 1);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [L-1:0]     idx_q, idx_d;
  logic [L-1:0]     acc_q, acc_d;
  logic [L:0]       ones_q, ones_d;
  logic [QUANT-1:0] data_q, data_d;
  logic [L:0]       c;
  logic [QUANT-1:0] sample;

  // Final count includes the bit being accepted this cycle.
  assign c = (L+1)'(acc_q) + (L+1)'(bus.bit_in);

`ifdef BITSTREAM_DECODE_SAT_EN
  localparam logic signed [QUANT+1:0] Q_MAX = (QUANT+2)'(H - 1);
  localparam logic signed [QUANT+1:0] Q_MIN = (QUANT+2)'(1 - H);

  logic [QUANT:0]          u;
  logic signed [QUANT+1:0] q;

  always_comb begin
    u = (QUANT+1)'(c) << S;
    q = $signed({1'b0, u}) - $signed((QUANT+2)'(H));
    if (q > Q_MAX) begin
      sample = Q_MAX[QUANT-1:0];
    end else if (q < Q_MIN) begin
      sample = Q_MIN[QUANT-1:0];
    end else begin
      sample = q[QUANT-1:0];
    end
  end
`else
  // Modulo 2**QUANT arithmetic gives the plain wrap directly.
  assign sample = (QUANT'(c) << S) - QUANT'(H);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ones_d  = ones_q;
    data_d  = data_q;
    case (state_q)
      ACC: begin
        if (bus.in_valid) begin
          if (idx_q == LAST_IDX) begin
            ones_d  = c;
            data_d  = sample;
            idx_d   = '0;
            acc_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + L'(1);
            acc_d = acc_q + L'(bus.bit_in);
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = ACC;
        end
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      idx_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = (state_q == DONE);
  assign bus.data      = data_q;
  assign bus.ones      = ones_q;
endmodule

// File: tb/tb_bitstream_decode.sv
// Self-checking bench for bitstream_decode (BITSTREAM=64, QUANT=8); honours BITSTREAM_DECODE_SAT_EN.
module tb_bitstream_decode;
  localparam int BITSTREAM = 64;
  localparam int QUANT     = 8;
  localparam int S         = 2;
  localparam int H         = 128;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bitstream_decode_if #(.BITSTREAM(BITSTREAM), .QUANT(QUANT)) bif ();

  bitstream_decode #(.BITSTREAM(BITSTREAM), .QUANT(QUANT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference: decoded value = count scaled to the QUANT grid, offset by half range.
  function automatic logic [7:0] model_data(input int c);
    int q;
    q = c * (2 ** S) - H;
`ifdef BITSTREAM_DECODE_SAT_EN
    if (q > H - 1) q = H - 1;
    if (q < 1 - H) q = 1 - H;
`endif
    return 8'(q);
  endfunction

  function automatic logic [63:0] make_frame(input int k);
    logic       b [64];
    logic [63:0] f;
    for (int i = 0; i < 64; i++) b[i] = (i < k);
    for (int i = 63; i > 0; i--) begin
      int   j;
      logic t;
      j    = int'($urandom_range(i, 0));
      t    = b[i];
      b[i] = b[j];
      b[j] = t;
    end
    for (int i = 0; i < 64; i++) f[i] = b[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams f[0] first; counts mid-frame output disturbances; returns right after the last bit's edge.
  task automatic drive_frame(input logic [63:0] f, input int gap_pct,
                             output int mid_bad, output bit timed_out);
    int          i;
    int          n;
    logic [7:0]  d0;
    logic [6:0]  o0;
    i = 0; n = 0; mid_bad = 0; timed_out = 0;
    d0 = bif.data;
    o0 = bif.ones;
    while (i < BITSTREAM && !timed_out) begin
      if (int'($urandom_range(99, 0)) < gap_pct) begin
        bif.in_valid = 1'b0;
        bif.bit_in   = 1'($urandom);
      end else begin
        bif.in_valid = 1'b1;
        bif.bit_in   = f[i];
      end
      if (bif.in_valid && bif.in_ready) i++;
      tick();
      if (i < BITSTREAM && (bif.out_valid !== 1'b0 || bif.data !== d0 || bif.ones !== o0))
        mid_bad++;
      n++;
      if (n > 4000) timed_out = 1;
    end
    bif.in_valid = 1'b0;
    bif.bit_in   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bif.in_valid = 1'($urandom);
      bif.bit_in   = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    bif.in_valid = 1'b0;
    bif.bit_in   = 1'b0;
    checks++;
    if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
    checks++;
    if (bif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bif.in_ready); end
    checks++;
    if (bif.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bif.data); end
    checks++;
    if (bif.ones !== 7'd0) begin errors++; $display("FAIL reset_ones: got %0d want 0", bif.ones); end
  endtask

  task automatic test_patterns();
    logic [63:0] pats [4];
    int          mid_bad;
    bit          to;
    int          c;
    pats[0] = 64'h0;
    pats[1] = 64'h5555_5555_5555_5555;
    pats[2] = 64'h0000_FFFF_FFFF_FFFF;
    pats[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    bif.out_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      c = $countones(pats[p]);
      drive_frame(pats[p], 0, mid_bad, to);
      checks++;
      if (to || mid_bad != 0) begin
        errors++; $display("FAIL pat%0d_midframe: disturbances %0d timeout %0d want 0", p, mid_bad, to);
      end
      checks++;
      if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0) begin
        errors++; $display("FAIL pat%0d_latency: out_valid %b in_ready %b want 1/0", p, bif.out_valid, bif.in_ready);
      end
      checks++;
      if (bif.ones !== 7'(c)) begin errors++; $display("FAIL pat%0d_ones: got %0d want %0d", p, bif.ones, c); end
      checks++;
      if (bif.data !== model_data(c)) begin
        errors++; $display("FAIL pat%0d_data: got %h want %h", p, bif.data, model_data(c));
      end
      tick();
      checks++;
      if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
        errors++; $display("FAIL pat%0d_handshake: out_valid %b in_ready %b want 0/1", p, bif.out_valid, bif.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] f;
    int          mid_bad;
    bit          to;
    int          bad;
    int          k;
    bif.out_ready = 1'b0;
    f = make_frame(41);
    drive_frame(f, 40, mid_bad, to);
    checks++;
    if (to || mid_bad != 0) begin errors++; $display("FAIL bp_midframe: disturbances %0d timeout %0d want 0", mid_bad, to); end
    checks++;
    if (bif.ones !== 7'd41 || bif.data !== model_data(41)) begin
      errors++; $display("FAIL bp_result: ones %0d data %h want 41/%h", bif.ones, bif.data, model_data(41));
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      bif.in_valid = 1'($urandom);
      bif.bit_in   = 1'($urandom);
      tick();
      if (bif.out_valid !== 1'b1 || bif.in_ready !== 1'b0 || bif.ones !== 7'd41 || bif.data !== model_data(41))
        bad++;
    end
    bif.in_valid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    bif.out_ready = 1'b1;
    tick();
    bif.out_ready = 1'b0;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid %b in_ready %b want 0/1", bif.out_valid, bif.in_ready);
    end
    k = int'($urandom_range(64, 0));
    f = make_frame(k);
    drive_frame(f, 20, mid_bad, to);
    checks++;
    if (to || bif.out_valid !== 1'b1 || bif.ones !== 7'(k) || bif.data !== model_data(k)) begin
      errors++; $display("FAIL bp_next_frame: valid %b ones %0d data %h want 1/%0d/%h", bif.out_valid, bif.ones, bif.data, k, model_data(k));
    end
    bif.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    int mid_bad;
    bit to;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bif.in_valid = 1'b1;
      bif.bit_in   = 1'b1;
      tick();
    end
    bif.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_frame(64'h0, 0, mid_bad, to);
    checks++;
    if (to || bif.out_valid !== 1'b1 || bif.ones !== 7'd0 || bif.data !== model_data(0)) begin
      errors++; $display("FAIL rstmid_discard: valid %b ones %0d data %h want 1/0/%h", bif.out_valid, bif.ones, bif.data, model_data(0));
    end
    tick();
    bif.out_ready = 1'b0;
    drive_frame(make_frame(10), 0, mid_bad, to);
    checks++;
    if (to || bif.out_valid !== 1'b1 || bif.ones !== 7'd10) begin
      errors++; $display("FAIL rstdone_setup: valid %b ones %0d want 1/10", bif.out_valid, bif.ones);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bif.out_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.ones !== 7'd0 || bif.data !== 8'h00) begin
      errors++; $display("FAIL rstdone_clear: valid %b rdy %b ones %0d data %h want 0/1/0/00", bif.out_valid, bif.in_ready, bif.ones, bif.data);
    end
  endtask

  task automatic test_round_trip();
    int          mid_bad;
    bit          to;
    int          c;
    int          diff;
    logic signed [7:0] ds;
    bif.out_ready = 1'b1;
    for (int q = 1 - H; q <= H - 1; q++) begin
      c = (q + H) >> S;
      drive_frame(make_frame(c), 10, mid_bad, to);
      ds   = bif.data;
      diff = int'(ds) - q;
      checks++;
      if (to || bif.ones !== 7'(c) || diff > 3 || diff < -3) begin
        errors++; $display("FAIL roundtrip q=%0d: ones %0d data %0d want ones %0d |err|<=3", q, bif.ones, ds, c);
      end
      checks++;
      if ($isunknown({bif.in_ready, bif.out_valid, bif.data, bif.ones})) begin
        errors++; $display("FAIL roundtrip_x q=%0d: outputs %b want no X", q, {bif.in_ready, bif.out_valid, bif.data, bif.ones});
      end
      tick();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bif.in_valid  = 1'b0;
    bif.bit_in    = 1'b0;
    bif.out_ready = 1'b0;
    test_reset();
    test_patterns();
    test_backpressure();
    test_reset_mid();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
